// File: rtl/avalon_input_pio_pkg.sv
// Shared register map, default ID word and counter sizing for the Avalon input PIO.
package avalon_input_pio_pkg;

    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_MASK = 2'd1;
    localparam logic [1:0] REG_EDGE = 2'd2;
    localparam logic [1:0] REG_ID   = 2'd3;

    localparam logic [31:0] DEFAULT_ID_VALUE = 32'h5049_4F31;

    // Counter must hold DEBOUNCE_CYCLES-1; never narrower than one bit.
    function automatic int cntWidth(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One input bit: two-flop synchronizer, stability counter and debounced flop.
module debounce_bit
    import avalon_input_pio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit INVERT          = 1'b0
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic raw_i,
    output logic deb_o,
    output logic debNext_o
);

    localparam int CW = cntWidth(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic sync1_q;
    logic sync2_q;
    logic deb_q;
    logic deb_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Polarity is corrected on entry so the all-zero reset state already means
    // "released" for active-low keys, avoiding a transient mismatch after reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i ^ INVERT;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            deb_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            deb_q <= deb_d;
            cnt_q <= cnt_d;
        end
    end

    assign deb_o     = deb_q;
    assign debNext_o = deb_d;

endmodule

// File: rtl/avalon_input_pio.sv
// Avalon-MM responder exposing debounced SW/KEY inputs, sticky edge capture and a masked level IRQ.
module avalon_input_pio
    import avalon_input_pio_pkg::*;
#(
    parameter int               WIDTH           = 12,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter logic [WIDTH-1:0] INVERT_MASK     = WIDTH'(12'hF00),
    parameter logic [31:0]      ID_VALUE        = DEFAULT_ID_VALUE
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [1:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             irq,
    input  logic [WIDTH-1:0] pio_in
);

    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] debNext;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .INVERT          (INVERT_MASK[i])
        ) u_debounce (
            .clk_i     (CLK),
            .rst_n_i   (RESET_N),
            .raw_i     (pio_in[i]),
            .deb_o     (deb[i]),
            .debNext_o (debNext[i])
        );
    end

    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic [WIDTH-1:0] edgeCapture_q;
    logic [WIDTH-1:0] edgeCapture_d;
    logic [WIDTH-1:0] clearBits;
    logic [31:0]      readData_q;
    logic [31:0]      readData_d;
    logic             irq_q;
    logic             irq_d;
    logic             unusedWriteBits;

    assign unusedWriteBits = ^avs_writedata[31:WIDTH];

    // Readback samples current register contents, so a same-cycle write or
    // edge is only visible on the following read; a new edge beats a clear.
    always_comb begin
        mask_d    = mask_q;
        clearBits = '0;
        if (avs_write && avs_address == REG_MASK) begin
            mask_d = avs_writedata[WIDTH-1:0];
        end
        if (avs_write && avs_address == REG_EDGE) begin
            clearBits = avs_writedata[WIDTH-1:0];
        end
        edgeCapture_d = (edgeCapture_q & ~clearBits) | (debNext ^ deb);
        irq_d         = |(edgeCapture_d & mask_d);

        readData_d = readData_q;
        if (avs_read) begin
            case (avs_address)
                REG_DATA: readData_d = 32'(deb);
                REG_MASK: readData_d = 32'(mask_q);
                REG_EDGE: readData_d = 32'(edgeCapture_q);
                REG_ID:   readData_d = ID_VALUE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            mask_q        <= '0;
            edgeCapture_q <= '0;
            readData_q    <= '0;
            irq_q         <= 1'b0;
        end else begin
            mask_q        <= mask_d;
            edgeCapture_q <= edgeCapture_d;
            readData_q    <= readData_d;
            irq_q         <= irq_d;
        end
    end

    assign avs_readdata = readData_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_avalon_input_pio.sv
// Directed and randomized checks of avalon_input_pio against a window-based behavioural model.
module tb_avalon_input_pio;
    import avalon_input_pio_pkg::*;

    localparam int          W   = 12;
    localparam int          DCY = 4;
    localparam logic [W-1:0] INV = 12'hF00;
    localparam logic [31:0] IDV = 32'h5049_4F31;

    logic          CLK = 1'b0;
    logic          RESET_N = 1'b1;
    logic [1:0]    avs_address = 2'd0;
    logic          avs_read = 1'b0;
    logic          avs_write = 1'b0;
    logic [31:0]   avs_writedata = 32'd0;
    logic [31:0]   avs_readdata;
    logic          irq;
    logic [W-1:0]  pio_in = 12'hF00;

    int checks = 0;
    int failures = 0;

    logic [W-1:0]  curPin = 12'hF00;
    logic [W-1:0]  mDeb;
    logic [W-1:0]  mMask;
    logic [W-1:0]  mEdge;
    logic [31:0]   mRd;
    logic          mIrq;
    logic [W-1:0]  mDelay[$];
    logic [W-1:0]  mWin[$];

    avalon_input_pio #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (DCY),
        .INVERT_MASK     (INV),
        .ID_VALUE        (IDV)
    ) dut (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .irq           (irq),
        .pio_in        (pio_in)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mDeb  = '0;
        mMask = '0;
        mEdge = '0;
        mRd   = '0;
        mIrq  = 1'b0;
        mDelay.delete();
        mDelay.push_back('0);
        mDelay.push_back('0);
        mWin.delete();
    endtask

    // A debounced bit flips once the last DCY synchronized samples all disagree with it.
    task automatic modelStep(input logic [1:0] addr, input logic rd, input logic wr,
                             input logic [31:0] wdata, input logic [W-1:0] pin);
        logic [W-1:0] s;
        logic [W-1:0] debN;
        logic [W-1:0] clr;
        logic [W-1:0] maskN;
        logic [W-1:0] edgeN;
        bit flip;
        s = mDelay.pop_front();
        mDelay.push_back(pin ^ INV);
        mWin.push_back(s);
        if (mWin.size() > DCY) void'(mWin.pop_front());
        debN = mDeb;
        for (int i = 0; i < W; i++) begin
            flip = (mWin.size() == DCY);
            foreach (mWin[j]) if (mWin[j][i] == mDeb[i]) flip = 0;
            if (flip) debN[i] = ~mDeb[i];
        end
        if (rd) begin
            if (addr == 2'd0)      mRd = {20'd0, mDeb};
            else if (addr == 2'd1) mRd = {20'd0, mMask};
            else if (addr == 2'd2) mRd = {20'd0, mEdge};
            else                   mRd = IDV;
        end
        clr   = (wr && addr == 2'd2) ? wdata[W-1:0] : '0;
        maskN = (wr && addr == 2'd1) ? wdata[W-1:0] : mMask;
        edgeN = (mEdge & ~clr) | (debN ^ mDeb);
        mIrq  = |(edgeN & maskN);
        mDeb  = debN;
        mMask = maskN;
        mEdge = edgeN;
    endtask

    task automatic applyStimulus(input logic [1:0] addr, input logic rd, input logic wr,
                                 input logic [31:0] wdata, input logic [W-1:0] pin);
        avs_address   = addr;
        avs_read      = rd;
        avs_write     = wr;
        avs_writedata = wdata;
        pio_in        = pin;
        @(posedge CLK);
        modelStep(addr, rd, wr, wdata, pin);
        @(negedge CLK);
        checkOutput("irq", {31'd0, irq}, {31'd0, mIrq});
        checkOutput("readdata", avs_readdata, mRd);
    endtask

    task automatic readReg(input logic [1:0] addr);
        applyStimulus(addr, 1'b1, 1'b0, 32'd0, curPin);
    endtask

    task automatic writeReg(input logic [1:0] addr, input logic [31:0] data);
        applyStimulus(addr, 1'b0, 1'b1, data, curPin);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(2'd0, 1'b0, 1'b0, 32'd0, curPin);
    endtask

    initial begin
        int hold;
        logic [1:0] rAddr;
        logic rRd;
        logic rWr;

        // Power-on reset with switches low and keys released.
        #1 RESET_N = 1'b0;
        @(negedge CLK);
        checkOutput("resetIrq", {31'd0, irq}, 32'd0);
        checkOutput("resetReadData", avs_readdata, 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        modelReset();
        idle(2);
        readReg(REG_DATA);
        checkOutput("dataAfterReset", avs_readdata, 32'd0);
        readReg(REG_ID);
        checkOutput("idReg", avs_readdata, 32'h5049_4F31);
        idle(8);

        // SW[3] rises: debounced value appears exactly 6 edges later.
        curPin = 12'hF08;
        for (int k = 1; k <= 7; k++) begin
            readReg(REG_DATA);
            if (k == 6) checkOutput("swLatencyBefore", avs_readdata, 32'd0);
            if (k == 7) checkOutput("swLatencyAfter", avs_readdata, 32'h008);
        end
        readReg(REG_EDGE);
        checkOutput("edgeSw3", avs_readdata, 32'h008);
        checkOutput("irqMasked", {31'd0, irq}, 32'd0);

        // Three-cycle glitch on SW[0] must be rejected.
        curPin = 12'hF09;
        idle(3);
        curPin = 12'hF08;
        idle(6);
        readReg(REG_DATA);
        checkOutput("glitchData", avs_readdata, 32'h008);
        readReg(REG_EDGE);
        checkOutput("glitchEdge", avs_readdata, 32'h008);

        // Enable KEY[0] interrupt and press the key.
        writeReg(REG_MASK, 32'h100);
        curPin = 12'hE08;
        idle(8);
        readReg(REG_DATA);
        checkOutput("keyData", avs_readdata, 32'h108);
        checkOutput("keyIrq", {31'd0, irq}, 32'd1);
        writeReg(REG_EDGE, 32'h100);
        checkOutput("irqCleared", {31'd0, irq}, 32'd0);
        readReg(REG_EDGE);
        checkOutput("edgeAfterClear", avs_readdata, 32'h008);

        // Release KEY[0] and clear bit 8 on the very edge where the release lands.
        curPin = 12'hF08;
        idle(5);
        writeReg(REG_EDGE, 32'h100);
        checkOutput("setBeatsClearIrq", {31'd0, irq}, 32'd1);
        readReg(REG_EDGE);
        checkOutput("setBeatsClearEdge", avs_readdata, 32'h108);

        // Asynchronous reset while the interrupt is pending.
        readReg(REG_ID);
        RESET_N = 1'b0;
        avs_read = 1'b0;
        avs_write = 1'b0;
        #1;
        checkOutput("midResetIrq", {31'd0, irq}, 32'd0);
        checkOutput("midResetReadData", avs_readdata, 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        modelReset();
        readReg(REG_EDGE);
        checkOutput("edgeAfterReset", avs_readdata, 32'd0);
        readReg(REG_MASK);
        checkOutput("maskAfterReset", avs_readdata, 32'd0);
        for (int k = 0; k < 5; k++) readReg(REG_DATA);
        checkOutput("resettleData", avs_readdata, 32'h008);

        // Randomized inputs and bus traffic against the model.
        hold = 0;
        for (int k = 0; k < 500; k++) begin
            if (hold == 0) begin
                hold = $urandom_range(1, 9);
                if ($urandom_range(0, 2) == 0) curPin = W'($urandom);
            end
            hold--;
            rAddr = 2'($urandom_range(0, 3));
            rRd   = ($urandom_range(0, 1) == 1);
            rWr   = ($urandom_range(0, 3) == 0);
            applyStimulus(rAddr, rRd, rWr, $urandom, curPin);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
